mem_wb_pipe: RTL and testbench

- Parametrised MEM/WB pipeline register. It carries the memory read data, ALU result, destination register indices and writeback control from the MEM stage to the WB stage, across DEPTH register stages.
- Adds the following:
  - a valid bit per stage
  - synchronous stall and flush
  - writeback-data selection
  - a forwarding lookup across all in-flight stages.
- Sits between the data-memory stage and the register-file write port. The hazard unit drives stall/flush and consumes the forwarding result.

---
 rtl/mem_wb_pipe_pkg.sv | 49 ++++
 rtl/mem_wb_pipe_fwd_lookup.sv | 43 ++++
 rtl/mem_wb_pipe.sv | 181 ++++++++++++++++++
 tb/tb_mem_wb_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared types and helpers for the MEM/WB pipeline register and its
//   forwarding lookup. A pipeline slot is stored at the package widths
//   (DATA_W_DEF / REG_W_DEF). Narrower instances zero-extend into the slot.
//
//   mem_wb_ctrl_t : valid, reg_dst, reg_write, mem_to_reg
//   mem_wb_slot_t : ctrl, dato_mem, alu, rd, rt
//   wb_addr(slot) : destination register (reg_dst ? rd : rt)
//   wb_data(slot) : writeback data (mem_to_reg ? dato_mem : alu)
//   slot_writes() : slot is a live register write to a given non-zero index
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int DEPTH_MAX  = 4;

    typedef struct packed {
        logic valid;
        logic reg_dst;
        logic reg_write;
        logic mem_to_reg;
    } mem_wb_ctrl_t;

    typedef struct packed {
        mem_wb_ctrl_t            ctrl;
        logic [DATA_W_DEF-1:0]   dato_mem;
        logic [DATA_W_DEF-1:0]   alu;
        logic [REG_W_DEF-1:0]    rd;
        logic [REG_W_DEF-1:0]    rt;
    } mem_wb_slot_t;

    function automatic logic [REG_W_DEF-1:0] wb_addr(input mem_wb_slot_t slot);
        return slot.ctrl.reg_dst ? slot.rd : slot.rt;
    endfunction

    function automatic logic [DATA_W_DEF-1:0] wb_data(input mem_wb_slot_t slot);
        return slot.ctrl.mem_to_reg ? slot.dato_mem : slot.alu;
    endfunction

    // Register 0 is hard-wired, so a write to it never counts as a producer.
    function automatic logic slot_writes(input mem_wb_slot_t slot,
                                         input logic [REG_W_DEF-1:0] idx);
        return slot.ctrl.valid && slot.ctrl.reg_write &&
               (wb_addr(slot) == idx) && (idx != {REG_W_DEF{1'b0}});
    endfunction

endpackage

// File: rtl/mem_wb_pipe_fwd_lookup.sv
// ---------------------------------------------------------------------------
// mem_wb_fwd_lookup
//   Combinational priority search over DEPTH in-flight pipeline slots.
//   Slot 0 is the youngest; the youngest slot writing q_rs supplies q_data.
//   Reusable by any stage that keeps its slots in mem_wb_slot_t form.
//
//   Ports:
//     slots  [DEPTH] in   in-flight slots, index 0 = youngest
//     q_rs           in   queried register index
//     q_hit          out  some valid slot writes q_rs (q_rs != 0)
//     q_data         out  writeback data of the youngest matching slot, else 0
// ---------------------------------------------------------------------------
module mem_wb_fwd_lookup
    import pipe_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  mem_wb_slot_t            slots [DEPTH],
    input  logic [REG_W_DEF-1:0]    q_rs,
    output logic                    q_hit,
    output logic [DATA_W_DEF-1:0]   q_data
);

    logic [DEPTH-1:0] hit_vec_s;

    // Per-slot match flags.
    always_comb begin
        hit_vec_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            hit_vec_s[k] = slot_writes(slots[k], q_rs);
        end
    end

    // Scan oldest to youngest so the youngest match is applied last and wins.
    always_comb begin
        q_hit  = |hit_vec_s;
        q_data = {DATA_W_DEF{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            q_data = hit_vec_s[k] ? wb_data(slots[k]) : q_data;
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe
//   MEM/WB pipeline register, DEPTH stages deep (latency = DEPTH cycles),
//   with per-stage valid, synchronous stall/flush, writeback selection and a
//   forwarding lookup over every in-flight stage.
//
//   Priority on each rising edge: rst > flush > stall > advance.
//     rst   : every field of every stage loads 0.
//     flush : valid/reg_write/mem_to_reg clear; data and indices are kept.
//     stall : nothing updates and the inputs are ignored.
//     else  : stages shift by one; an invalid input enters as a bubble with
//             all control bits 0 and stage 0's previous data retained.
//
//   Ports:
//     clk, rst (sync, active-high), stall, flush
//     in_valid, in_dato_mem, in_alu, in_rd, in_rt,
//     in_reg_dst, in_reg_write, in_mem_to_reg        MEM-stage slot
//     out_valid, out_dato_mem, out_alu, out_rd, out_rt last stage contents
//     out_wr_addr, out_wr_en, out_wb_data             resolved writeback
//     q_rs -> q_hit, q_data                           forwarding query
//   Optional (macro MEM_WB_PIPE_PERF_EN):
//     perf_retired, perf_stall, perf_flush            32-bit wrapping counters
// ---------------------------------------------------------------------------
module mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_dato_mem,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rt,
    input  logic              in_reg_dst,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_dato_mem,
    output logic [DATA_W-1:0] out_alu,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_wr_addr,
    output logic              out_wr_en,
    output logic [DATA_W-1:0] out_wb_data,
    input  logic [REG_W-1:0]  q_rs,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data
`ifdef MEM_WB_PIPE_PERF_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush
`endif
);

    // Elaboration-time parameter checks.
    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $fatal(1, "mem_wb_pipe: DEPTH must be in 1..4");
    end
    if (DATA_W < 1 || DATA_W > DATA_W_DEF || REG_W < 1 || REG_W > REG_W_DEF) begin : g_bad_width
        $fatal(1, "mem_wb_pipe: DATA_W/REG_W exceed the pipe_pkg slot widths");
    end

    mem_wb_slot_t              stage_r [DEPTH];
    mem_wb_slot_t              in_slot_s;
    mem_wb_slot_t              last_s;
    logic [REG_W_DEF-1:0]      last_addr_s;
    logic [DATA_W_DEF-1:0]     last_data_s;
    logic                      fwd_hit_s;
    logic [DATA_W_DEF-1:0]     fwd_data_s;

    // Build the slot entering stage 0; a bubble keeps stage 0's old payload.
    always_comb begin
        in_slot_s      = stage_r[0];
        in_slot_s.ctrl = '0;
        if (in_valid) begin
            in_slot_s.ctrl.valid      = 1'b1;
            in_slot_s.ctrl.reg_dst    = in_reg_dst;
            in_slot_s.ctrl.reg_write  = in_reg_write;
            in_slot_s.ctrl.mem_to_reg = in_mem_to_reg;
            in_slot_s.dato_mem        = DATA_W_DEF'(in_dato_mem);
            in_slot_s.alu             = DATA_W_DEF'(in_alu);
            in_slot_s.rd              = REG_W_DEF'(in_rd);
            in_slot_s.rt              = REG_W_DEF'(in_rt);
        end else begin
            in_slot_s.ctrl.valid      = 1'b0;
        end
    end

    // Stage registers: reset, flush, hold or shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= '0;
            end
        end else if (flush) begin
            // Payload is left in place; only the bits that make a stage live go low.
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k].ctrl.valid      <= 1'b0;
                stage_r[k].ctrl.reg_write  <= 1'b0;
                stage_r[k].ctrl.mem_to_reg <= 1'b0;
            end
        end else if (!stall) begin
            stage_r[0] <= in_slot_s;
            for (int k = 1; k < DEPTH; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    // Writeback view of the last stage.
    always_comb begin
        last_s      = stage_r[DEPTH-1];
        last_addr_s = wb_addr(last_s);
        last_data_s = wb_data(last_s);
    end

    assign out_valid    = last_s.ctrl.valid;
    assign out_dato_mem = last_s.dato_mem[DATA_W-1:0];
    assign out_alu      = last_s.alu[DATA_W-1:0];
    assign out_rd       = last_s.rd[REG_W-1:0];
    assign out_rt       = last_s.rt[REG_W-1:0];
    assign out_wr_addr  = last_addr_s[REG_W-1:0];
    assign out_wb_data  = last_data_s[DATA_W-1:0];
    assign out_wr_en    = last_s.ctrl.valid && last_s.ctrl.reg_write &&
                          (last_addr_s != {REG_W_DEF{1'b0}});

    mem_wb_fwd_lookup #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .slots  (stage_r),
        .q_rs   (REG_W_DEF'(q_rs)),
        .q_hit  (fwd_hit_s),
        .q_data (fwd_data_s)
    );

    assign q_hit  = fwd_hit_s;
    assign q_data = fwd_data_s[DATA_W-1:0];

`ifdef MEM_WB_PIPE_PERF_EN
    logic [31:0] perf_retired_r;
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;
    logic        retire_s;

    // An instruction leaves the pipe when it writes a real register or does
    // not write at all; a valid write to r0 is not counted.
    always_comb begin
        retire_s = 1'b0;
        if (!stall && last_s.ctrl.valid) begin
            retire_s = out_wr_en || !last_s.ctrl.reg_write;
        end else begin
            retire_s = 1'b0;
        end
    end

    // Event counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired_r <= 32'd0;
            perf_stall_r   <= 32'd0;
            perf_flush_r   <= 32'd0;
        end else begin
            perf_retired_r <= perf_retired_r + {31'd0, retire_s};
            perf_stall_r   <= perf_stall_r   + {31'd0, stall};
            perf_flush_r   <= perf_flush_r   + {31'd0, flush};
        end
    end

    assign perf_retired = perf_retired_r;
    assign perf_stall   = perf_stall_r;
    assign perf_flush   = perf_flush_r;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe (DEPTH=3). The stimulus process pushes
// each accepted instruction, with its expected writeback and the advance
// count at which it must reach the last stage, into a queue. The monitor
// pops at that count and compares; the forwarding answer is recomputed from
// the set of instructions still in flight.
module tb_mem_wb_pipe;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_dato_mem = 32'd0;
    logic [31:0] in_alu = 32'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rt = 5'd0;
    logic        in_reg_dst = 1'b0;
    logic        in_reg_write = 1'b0;
    logic        in_mem_to_reg = 1'b0;
    logic [4:0]  q_rs = 5'd0;

    logic        out_valid, out_wr_en, q_hit;
    logic [31:0] out_dato_mem, out_alu, out_wb_data, q_data;
    logic [4:0]  out_rd, out_rt, out_wr_addr;
`ifdef MEM_WB_PIPE_PERF_EN
    logic [31:0] perf_retired, perf_stall, perf_flush;
`endif

    mem_wb_pipe #(.DATA_W(32), .REG_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_dato_mem(in_dato_mem), .in_alu(in_alu),
        .in_rd(in_rd), .in_rt(in_rt), .in_reg_dst(in_reg_dst),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .out_valid(out_valid), .out_dato_mem(out_dato_mem), .out_alu(out_alu),
        .out_rd(out_rd), .out_rt(out_rt), .out_wr_addr(out_wr_addr),
        .out_wr_en(out_wr_en), .out_wb_data(out_wb_data),
        .q_rs(q_rs), .q_hit(q_hit), .q_data(q_data)
`ifdef MEM_WB_PIPE_PERF_EN
        , .perf_retired(perf_retired), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic        wr_en;
        logic        reg_write;
        logic [31:0] wb;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [4:0]  rt;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned s_adv = 0;
    int unsigned m_adv = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs (at negedge) and record what the model expects.
    task automatic drive(input logic r, input logic f, input logic s, input logic v,
                         input logic rdst, input logic rw, input logic m2r,
                         input logic [4:0] rd, input logic [4:0] rt, input logic [4:0] qrs,
                         input logic [31:0] mem, input logic [31:0] alu);
        exp_t e;
        @(negedge clk);
        rst = r; flush = f; stall = s; in_valid = v;
        in_reg_dst = rdst; in_reg_write = rw; in_mem_to_reg = m2r;
        in_rd = rd; in_rt = rt; q_rs = qrs; in_dato_mem = mem; in_alu = alu;
        if (r || f) begin
            sb.delete();
        end else if (!s) begin
            s_adv++;
            if (v) begin
                e.addr      = rdst ? rd : rt;
                e.reg_write = rw;
                e.wr_en     = rw && (e.addr != 5'd0);
                e.wb        = m2r ? mem : alu;
                e.mem = mem; e.alu = alu; e.rd = rd; e.rt = rt;
                e.due       = s_adv + DEPTH - 1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic bubble(input logic [4:0] qrs);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, qrs, 32'd0, 32'd0);
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] alu, input logic [4:0] qrs);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, rd, 5'd9, qrs, 32'hA5A5_0000, alu);
    endtask

    task automatic rnd(input int p_stall, input int p_flush, input int p_rst);
        logic r, f, s;
        r = ($urandom_range(99) < p_rst);
        f = ($urandom_range(99) < p_flush);
        s = ($urandom_range(99) < p_stall);
        drive(r, f, s, ($urandom_range(99) < 70), 1'($urandom), 1'($urandom), 1'($urandom),
              5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
              $urandom, $urandom);
    endtask

    // Monitor: classify the edge, advance the model, compare every output.
    initial begin
        logic  e_rst, e_flush, e_stall, exp_valid, prev_valid, hit;
        logic [31:0] fdata;
        exp_t  cur, prev_cur;
        int unsigned p_ret, p_st, p_fl;
        exp_valid = 1'b0;
        cur = '{default: '0};
        p_ret = 0; p_st = 0; p_fl = 0;
        forever begin
            @(posedge clk);
            e_rst = rst; e_flush = flush; e_stall = stall;
            prev_valid = exp_valid; prev_cur = cur;
            #1;
            if (e_rst || e_flush) begin
                exp_valid = 1'b0;
            end else if (!e_stall) begin
                m_adv++;
                if (sb.size() > 0 && sb[0].due == m_adv) begin
                    cur = sb.pop_front();
                    exp_valid = 1'b1;
                end else begin
                    exp_valid = 1'b0;
                end
            end
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                chk("out_wr_addr", {27'd0, out_wr_addr}, {27'd0, cur.addr});
                chk("out_wr_en", {31'd0, out_wr_en}, {31'd0, cur.wr_en});
                chk("out_wb_data", out_wb_data, cur.wb);
                chk("out_alu", out_alu, cur.alu);
                chk("out_dato_mem", out_dato_mem, cur.mem);
                chk("out_rd", {27'd0, out_rd}, {27'd0, cur.rd});
                chk("out_rt", {27'd0, out_rt}, {27'd0, cur.rt});
            end else begin
                chk("out_wr_en_idle", {31'd0, out_wr_en}, 32'd0);
            end
            if (e_rst) begin
                chk("rst_alu", out_alu, 32'd0);
                chk("rst_mem", out_dato_mem, 32'd0);
                chk("rst_idx", {22'd0, out_rd, out_rt}, 32'd0);
                chk("rst_wb", out_wb_data, 32'd0);
            end
            // Youngest in-flight writer of q_rs; queue is ordered oldest first.
            hit = 1'b0; fdata = 32'd0;
            if (exp_valid && cur.reg_write && cur.addr == q_rs && q_rs != 5'd0) begin
                hit = 1'b1; fdata = cur.wb;
            end
            foreach (sb[i]) begin
                if (sb[i].reg_write && sb[i].addr == q_rs && q_rs != 5'd0) begin
                    hit = 1'b1; fdata = sb[i].wb;
                end
            end
            chk("q_hit", {31'd0, q_hit}, {31'd0, hit});
            chk("q_data", q_data, fdata);
`ifdef MEM_WB_PIPE_PERF_EN
            if (e_rst) begin
                p_ret = 0; p_st = 0; p_fl = 0;
            end else begin
                if (!e_stall && prev_valid && (prev_cur.wr_en || !prev_cur.reg_write)) p_ret++;
                if (e_stall) p_st++;
                if (e_flush) p_fl++;
            end
            chk("perf_retired", perf_retired, p_ret);
            chk("perf_stall", perf_stall, p_st);
            chk("perf_flush", perf_flush, p_fl);
`endif
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        // Reset.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 32'hFFFF_FFFF, 32'd1);
        // R-type write to r3.
        wr(5'd3, 32'h1234_5678, 5'd3);
        // Load into r7 through rt, followed by bubbles.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 5'd7, 5'd7, 32'hDEAD_BEEF, 32'h55);
        for (int i = 0; i < 4; i++) bubble(5'd7);
        // Stream with a 4-cycle stall; inputs during the stall must vanish.
        for (int i = 0; i < 3; i++) wr(5'(10 + i), 32'h100 + i, 5'd11);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd20, 5'd20, 5'd20, 32'd0, 32'hBAD0 + i);
        for (int i = 0; i < 3; i++) wr(5'(13 + i), 32'h200 + i, 5'd20);
        for (int i = 0; i < 4; i++) bubble(5'd14);
        // Two valid stages, then stall and flush on the same edge.
        wr(5'd8, 32'h808, 5'd8);
        wr(5'd9, 32'h909, 5'd8);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 5'd8, 5'd8, 32'd0, 32'hF1);
        bubble(5'd8);
        // r5 in stage 2 (0x22) and stage 0 (0x11): youngest must win.
        wr(5'd5, 32'h22, 5'd5);
        wr(5'd6, 32'h33, 5'd5);
        wr(5'd5, 32'h11, 5'd5);
        // Write to r0 queried with q_rs=0.
        wr(5'd0, 32'h44, 5'd0);
        for (int i = 0; i < 4; i++) bubble(5'd0);
        // Ten writes, three stall cycles, one flush, then reset.
        for (int i = 0; i < 10; i++) begin
            wr(5'(1 + i), 32'h300 + i, 5'(1 + i));
            if (i == 4) for (int j = 0; j < 3; j++)
                drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0);
        end
        for (int i = 0; i < 3; i++) bubble(5'd9);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) rnd(15, 4, 2);
        for (int i = 0; i < DEPTH + 2; i++) bubble(5'd0);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
